// File: rtl/ex_operand_stage_pkg.sv
// Shared types and constants for the ID/EX operand stage.
// Opcodes, width defaults and the bubble control word.
package ex_operand_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_ADD  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_RSVD = 3'b111;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       alu_src;
        logic [2:0] alu_op;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t CTRL_BUBBLE = '{
        valid:     1'b0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        alu_src:   1'b0,
        alu_op:    ALU_AND
    };

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Three-way operand select: EX/MEM result, MEM/WB result or
// the registered value. r0 never forwards.
module fwd_mux
    import ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              mem_wr,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_wr,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] fwd_data
);

    logic src_nz;
    logic mem_hit;
    logic wb_only;

    assign src_nz  = |src;
    assign mem_hit = src_nz & mem_wr & (mem_rd == src);
    // The younger EX/MEM result shadows MEM/WB.
    assign wb_only = src_nz & wb_wr & (wb_rd == src) & ~mem_hit;

    always_comb begin
        fwd_data = reg_data;
        unique case (1'b1)
            mem_hit: fwd_data = mem_data;
            wb_only: fwd_data = wb_data;
            default: fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register feeding the ALU, with immediate select.
// EX_FORWARDING_EN adds operand forwarding and load-use stall.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dec_valid,
    input  logic [DATA_W-1:0] dec_rs_data,
    input  logic [DATA_W-1:0] dec_rt_data,
    input  logic [REG_AW-1:0] dec_rs,
    input  logic [REG_AW-1:0] dec_rt,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic [15:0]       dec_imm,
    input  logic [2:0]        dec_alu_op,
    input  logic              dec_alu_src,
    input  logic              dec_imm_zext,
    input  logic              dec_reg_write,
    input  logic              dec_mem_read,
    input  logic              ex_flush,
    input  logic              ex_hold,
    input  logic              mem_wr,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_wr,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              dec_stall
);

    id_ex_ctrl_t       ctrl_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [REG_AW-1:0] rd_q;

    logic [DATA_W-1:0] dec_ext_imm;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic              load_bubble;

    assign dec_ext_imm = dec_imm_zext
        ? {{(DATA_W-16){1'b0}}, dec_imm}
        : {{(DATA_W-16){dec_imm[15]}}, dec_imm};

    // Flush beats hold; a stall only bubbles when not held.
    assign load_bubble = ex_flush | (~ex_hold & dec_stall);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q    <= CTRL_BUBBLE;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
        end else if (load_bubble) begin
            ctrl_q    <= CTRL_BUBBLE;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
        end else if (!ex_hold) begin
            ctrl_q.valid     <= dec_valid;
            ctrl_q.reg_write <= dec_reg_write;
            ctrl_q.mem_read  <= dec_mem_read;
            ctrl_q.alu_src   <= dec_alu_src;
            ctrl_q.alu_op    <= dec_alu_op;
            rs_data_q        <= dec_rs_data;
            rt_data_q        <= dec_rt_data;
            imm_q            <= dec_ext_imm;
            rs_q             <= dec_rs;
            rt_q             <= dec_rt;
            rd_q             <= dec_rd;
        end
    end

`ifdef EX_FORWARDING_EN
    logic load_use;

    fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rs (
        .src      (rs_q),
        .reg_data (rs_data_q),
        .mem_wr   (mem_wr),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .wb_wr    (wb_wr),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .fwd_data (rs_fwd)
    );

    fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rt (
        .src      (rt_q),
        .reg_data (rt_data_q),
        .mem_wr   (mem_wr),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .wb_wr    (wb_wr),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .fwd_data (rt_fwd)
    );

    assign load_use = ctrl_q.valid & ctrl_q.mem_read & (|rd_q)
                    & ((rd_q == dec_rs) | (rd_q == dec_rt))
                    & dec_valid;
    assign dec_stall = load_use & ~ex_flush;
`else
    logic unused_fwd;

    assign rs_fwd     = rs_data_q;
    assign rt_fwd     = rt_data_q;
    assign dec_stall  = 1'b0;
    assign unused_fwd = ^{mem_wr, mem_rd, mem_data,
                          wb_wr, wb_rd, wb_data,
                          rs_q, rt_q};
`endif

    assign alu_a         = rs_fwd;
    assign alu_b         = ctrl_q.alu_src ? imm_q : rt_fwd;
    assign alu_op        = ctrl_q.alu_op;
    assign ex_valid      = ctrl_q.valid;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_rd         = rd_q;
    assign ex_store_data = rt_fwd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios
// plus randomized traffic against a behavioural pipeline model.
module tb_ex_operand_stage;

`ifdef EX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dec_valid;
    logic [31:0] dec_rs_data, dec_rt_data;
    logic [4:0]  dec_rs, dec_rt, dec_rd;
    logic [15:0] dec_imm;
    logic [2:0]  dec_alu_op;
    logic        dec_alu_src, dec_imm_zext;
    logic        dec_reg_write, dec_mem_read;
    logic        ex_flush, ex_hold;
    logic        mem_wr, wb_wr;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_data, wb_data;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [2:0]  alu_op;
    logic        ex_valid, ex_reg_write, ex_mem_read, dec_stall;
    logic [4:0]  ex_rd;
    logic [107:0] dut_out;

    int n_cmp = 0;
    int n_fail = 0;

    // model of the instruction currently held in EX
    logic        m_valid, m_rw, m_mr, m_src;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_rs_data, m_rt_data, m_imm;
    logic [2:0]  m_op;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .reset_n(reset_n),
        .dec_valid(dec_valid),
        .dec_rs_data(dec_rs_data), .dec_rt_data(dec_rt_data),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd),
        .dec_imm(dec_imm), .dec_alu_op(dec_alu_op),
        .dec_alu_src(dec_alu_src), .dec_imm_zext(dec_imm_zext),
        .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
        .ex_flush(ex_flush), .ex_hold(ex_hold),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_store_data(ex_store_data), .dec_stall(dec_stall)
    );

    assign dut_out = {alu_a, alu_b, alu_op, ex_valid, ex_reg_write,
                      ex_mem_read, ex_rd, ex_store_data, dec_stall};

    function automatic logic exp_stall();
        if (!FWD || ex_flush || !dec_valid) return 1'b0;
        return m_valid && m_mr && m_rd != 0 &&
               (m_rd == dec_rs || m_rd == dec_rt);
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] a,
                                        input logic [31:0] v);
        if (FWD && a != 0 && mem_wr && mem_rd == a) return mem_data;
        if (FWD && a != 0 && wb_wr && wb_rd == a) return wb_data;
        return v;
    endfunction

    function automatic logic [107:0] model_out();
        logic [31:0] a, t, b;
        a = fwd(m_rs, m_rs_data);
        t = fwd(m_rt, m_rt_data);
        b = m_src ? m_imm : t;
        return {a, b, m_op, m_valid, m_rw, m_mr, m_rd, t, exp_stall()};
    endfunction

    task automatic model_clear();
        m_valid = 0; m_rw = 0; m_mr = 0; m_src = 0;
        m_rs = 0; m_rt = 0; m_rd = 0; m_op = 0;
        m_rs_data = 0; m_rt_data = 0; m_imm = 0;
    endtask

    // advance model by one edge, then the DUT clock
    task automatic tick();
        logic st;
        st = exp_stall();
        if (ex_flush || (!ex_hold && st)) begin
            model_clear();
        end else if (!ex_hold) begin
            m_valid = dec_valid; m_rw = dec_reg_write;
            m_mr = dec_mem_read; m_src = dec_alu_src;
            m_rs = dec_rs; m_rt = dec_rt; m_rd = dec_rd;
            m_op = dec_alu_op;
            m_rs_data = dec_rs_data; m_rt_data = dec_rt_data;
            if (dec_imm_zext)       m_imm = 32'(dec_imm);
            else if (dec_imm >= 16'h8000)
                m_imm = 32'(dec_imm) + 32'hFFFF_0000;
            else                    m_imm = 32'(dec_imm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        dec_valid = 0; dec_rs_data = 0; dec_rt_data = 0;
        dec_rs = 0; dec_rt = 0; dec_rd = 0; dec_imm = 0;
        dec_alu_op = 0; dec_alu_src = 0; dec_imm_zext = 0;
        dec_reg_write = 0; dec_mem_read = 0;
        ex_flush = 0; ex_hold = 0;
        mem_wr = 0; mem_rd = 0; mem_data = 0;
        wb_wr = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [31:0] rsd,
                             input logic [31:0] rtd, input logic [15:0] imm,
                             input logic [2:0] op, input logic src,
                             input logic zext, input logic mr);
        dec_valid = 1; dec_rs = rs; dec_rt = rt; dec_rd = rd;
        dec_rs_data = rsd; dec_rt_data = rtd; dec_imm = imm;
        dec_alu_op = op; dec_alu_src = src; dec_imm_zext = zext;
        dec_reg_write = 1; dec_mem_read = mr;
    endtask

    task automatic test_reset();
        drive_idle();
        reset_n = 0;
        model_clear();
        @(posedge clk); #1;
        n_cmp++;
        if (dut_out !== 108'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", dut_out);
        end
        reset_n = 1;
        #1;
    endtask

    task automatic test_add();
        set_instr(1, 2, 3, 15, 12, 16'h0, 3'b101, 0, 0, 0);
        tick();
        n_cmp++;
        if ({alu_a, alu_b, alu_op, ex_valid} !== {32'd15, 32'd12, 3'b101, 1'b1}) begin
            n_fail++;
            $display("FAIL add: got a=%0d b=%0d op=%b v=%b expected 15 12 101 1",
                     alu_a, alu_b, alu_op, ex_valid);
        end
        n_cmp++;
        if (dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL add_bundle: got %h expected %h", dut_out, model_out());
        end
    endtask

    task automatic test_imm_ext();
        set_instr(1, 2, 3, 15, 12, 16'hFFF0, 3'b101, 1, 0, 0);
        tick();
        n_cmp++;
        if (alu_b !== 32'hFFFF_FFF0) begin
            n_fail++;
            $display("FAIL imm_sext: got %h expected FFFFFFF0", alu_b);
        end
        dec_imm_zext = 1;
        tick();
        n_cmp++;
        if (alu_b !== 32'h0000_FFF0) begin
            n_fail++;
            $display("FAIL imm_zext: got %h expected 0000FFF0", alu_b);
        end
    endtask

    task automatic test_forwarding();
        logic [31:0] exp;
        set_instr(8, 9, 10, 100, 200, 16'h0, 3'b101, 0, 0, 0);
        tick();
        mem_wr = 1; mem_rd = 8; mem_data = 7;
        wb_wr = 1; wb_rd = 8; wb_data = 9;
        #1;
        exp = FWD ? 32'd7 : 32'd100;
        n_cmp++;
        if (alu_a !== exp) begin
            n_fail++;
            $display("FAIL fwd_mem_prio: got %0d expected %0d", alu_a, exp);
        end
        mem_wr = 0;
        #1;
        exp = FWD ? 32'd9 : 32'd100;
        n_cmp++;
        if (alu_a !== exp) begin
            n_fail++;
            $display("FAIL fwd_wb: got %0d expected %0d", alu_a, exp);
        end
        mem_wr = 1; mem_rd = 9; wb_rd = 0;
        #1;
        exp = FWD ? 32'd7 : 32'd200;
        n_cmp++;
        if (ex_store_data !== exp || alu_b !== exp) begin
            n_fail++;
            $display("FAIL fwd_rt: got st=%0d b=%0d expected %0d",
                     ex_store_data, alu_b, exp);
        end
        set_instr(0, 9, 10, 55, 200, 16'h0, 3'b101, 0, 0, 0);
        tick();
        mem_rd = 0; wb_rd = 0;
        #1;
        n_cmp++;
        if (alu_a !== 32'd55) begin
            n_fail++;
            $display("FAIL fwd_r0: got %0d expected 55", alu_a);
        end
        n_cmp++;
        if (dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL fwd_bundle: got %h expected %h", dut_out, model_out());
        end
        mem_wr = 0; wb_wr = 0;
    endtask

    task automatic test_load_use();
        set_instr(1, 2, 4, 32'h40, 0, 16'h0, 3'b101, 1, 0, 1);
        tick();
        set_instr(4, 5, 6, 33, 44, 16'h0, 3'b101, 0, 0, 0);
        #1;
        n_cmp++;
        if (dec_stall !== FWD) begin
            n_fail++;
            $display("FAIL lu_stall: got %b expected %b", dec_stall, FWD);
        end
        ex_hold = 1;
        tick();
        n_cmp++;
        if ({ex_mem_read, ex_rd, dec_stall} !== {1'b1, 5'd4, FWD}) begin
            n_fail++;
            $display("FAIL lu_hold: got mr=%b rd=%0d st=%b expected 1 4 %b",
                     ex_mem_read, ex_rd, dec_stall, FWD);
        end
        ex_hold = 0;
        tick();
        n_cmp++;
        if ({ex_valid, dec_stall} !== {!FWD, 1'b0}) begin
            n_fail++;
            $display("FAIL lu_bubble: got v=%b st=%b expected %b 0",
                     ex_valid, dec_stall, !FWD);
        end
        tick();
        n_cmp++;
        if ({ex_valid, ex_rd} !== {1'b1, 5'd6}) begin
            n_fail++;
            $display("FAIL lu_enter: got v=%b rd=%0d expected 1 6", ex_valid, ex_rd);
        end
        n_cmp++;
        if (dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL lu_bundle: got %h expected %h", dut_out, model_out());
        end
    endtask

    task automatic test_flush_hold();
        set_instr(1, 2, 4, 1, 2, 16'h0, 3'b101, 0, 0, 1);
        tick();
        set_instr(4, 4, 6, 3, 4, 16'h0, 3'b101, 0, 0, 0);
        ex_flush = 1; ex_hold = 1;
        #1;
        n_cmp++;
        if (dec_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall: got %b expected 0", dec_stall);
        end
        tick();
        n_cmp++;
        if ({ex_valid, dec_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_wins: got v=%b st=%b expected 0 0", ex_valid, dec_stall);
        end
        ex_flush = 0; ex_hold = 0;
        set_instr(3, 2, 7, 32'h1234, 32'h5678, 16'h0, 3'b110, 0, 0, 0);
        tick();
        ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            set_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), $urandom, $urandom,
                      16'($urandom), 3'($urandom_range(0, 7)), 0, 0, 0);
            tick();
            n_cmp++;
            if ({ex_rd, alu_a, alu_op, ex_valid} !== {5'd7, 32'h1234, 3'b110, 1'b1}) begin
                n_fail++;
                $display("FAIL hold_%0d: got rd=%0d a=%h op=%b v=%b expected 7 1234 110 1",
                         i, ex_rd, alu_a, alu_op, ex_valid);
            end
            n_cmp++;
            if (dut_out !== model_out()) begin
                n_fail++;
                $display("FAIL hold_bundle_%0d: got %h expected %h",
                         i, dut_out, model_out());
            end
        end
    endtask

    task automatic test_async_reset();
        dec_valid = 0;
        @(posedge clk); #3;
        reset_n = 0;
        model_clear();
        #1;
        n_cmp++;
        if (dut_out !== 108'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0", dut_out);
        end
        #2;
        ex_hold = 0;
        set_instr(2, 3, 9, 32'hA, 32'hB, 16'h0, 3'b001, 0, 0, 0);
        reset_n = 1;
        tick();
        n_cmp++;
        if ({ex_valid, ex_rd, alu_a} !== {1'b1, 5'd9, 32'hA}) begin
            n_fail++;
            $display("FAIL post_reset_load: got v=%b rd=%0d a=%h expected 1 9 A",
                     ex_valid, ex_rd, alu_a);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            dec_valid = ($urandom_range(0, 9) != 0);
            dec_rs = 5'($urandom_range(0, 7));
            dec_rt = 5'($urandom_range(0, 7));
            dec_rd = 5'($urandom_range(0, 7));
            dec_rs_data = $urandom; dec_rt_data = $urandom;
            dec_imm = 16'($urandom);
            dec_alu_op = 3'($urandom_range(0, 7));
            dec_alu_src = 1'($urandom_range(0, 1));
            dec_imm_zext = 1'($urandom_range(0, 1));
            dec_reg_write = 1'($urandom_range(0, 1));
            dec_mem_read = ($urandom_range(0, 2) == 0);
            ex_flush = ($urandom_range(0, 7) == 0);
            ex_hold = ($urandom_range(0, 5) == 0);
            mem_wr = 1'($urandom_range(0, 1));
            mem_rd = 5'($urandom_range(0, 7));
            mem_data = $urandom;
            wb_wr = 1'($urandom_range(0, 1));
            wb_rd = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            #1;
            n_cmp++;
            if (dut_out !== model_out()) begin
                n_fail++;
                $display("FAIL rand_comb_%0d: got %h expected %h",
                         i, dut_out, model_out());
            end
            tick();
            n_cmp++;
            if (dut_out !== model_out()) begin
                n_fail++;
                $display("FAIL rand_seq_%0d: got %h expected %h",
                         i, dut_out, model_out());
            end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm_ext();
        test_forwarding();
        test_load_use();
        test_flush_hold();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
